// File: rtl/date_set_ctrl_if.sv
// Bundle of the button/date inputs and the strobe/mode outputs of the
// calendar set-mode controller. The master side is the board/bench that
// drives buttons, the 1 Hz tick and the current date. The slave side is the
// controller itself.
interface date_set_ctrl_if;
    logic       tick_1hz;
    logic       btn_mode;
    logic       btn_inc;
    logic [4:0] day;
    logic [3:0] month;
    logic [6:0] year;
    logic       tick_o;
    logic       day_b;
    logic       mon_b;
    logic       year_b;
    logic       day_load;
    logic [4:0] day_load_val;
    logic [1:0] mode;

    modport master (
        output tick_1hz, btn_mode, btn_inc, day, month, year,
        input  tick_o, day_b, mon_b, year_b, day_load, day_load_val, mode
    );

    modport slave (
        input  tick_1hz, btn_mode, btn_inc, day, month, year,
        output tick_o, day_b, mon_b, year_b, day_load, day_load_val, mode
    );
endinterface

// File: rtl/date_set_ctrl.sv
// Set-mode controller for the day/month/year counters. Two debounced
// buttons walk RUN -> SET_DAY -> SET_MON -> SET_YEAR -> RUN; increment
// presses become single-cycle strobes to the selected counter. The 1 Hz
// tick is passed on only in RUN, idle set states fall back to RUN after
// TIMEOUT_S ticks, and leaving SET_MON/SET_YEAR clamps an illegal day.
module date_set_ctrl #(
    parameter int TIMEOUT_S = 30
) (
    input  logic           clk,
    input  logic           reset_n,
    date_set_ctrl_if.slave bus
);

    localparam logic [5:0] TO_LIMIT = 6'(TIMEOUT_S);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_SET_DAY  = 2'd1,
        ST_SET_MON  = 2'd2,
        ST_SET_YEAR = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic       prev_mode_q, prev_inc_q;
    logic [5:0] to_cnt_q, to_cnt_d;
    logic       tick_q;
    logic       day_b_q, day_b_d;
    logic       mon_b_q, mon_b_d;
    logic       year_b_q, year_b_d;
    logic       day_load_q, day_load_d;
    logic [4:0] day_load_val_q, day_load_val_d;

    logic       mode_press_s;
    logic       inc_press_s;
    logic [4:0] dim_s;

    // Days in month; February is leap whenever the two-digit year is a
    // multiple of four (valid for 2000..2099).
    function automatic logic [4:0] days_in_month(input logic [3:0] m, input logic [6:0] y);
        logic [4:0] d;
        case (m)
            4'd2:                      d = (y[1:0] == 2'b00) ? 5'd29 : 5'd28;
            4'd4, 4'd6, 4'd9, 4'd11:   d = 5'd30;
            default:                   d = 5'd31;
        endcase
        return d;
    endfunction

    assign mode_press_s = bus.btn_mode & ~prev_mode_q;
    assign inc_press_s  = bus.btn_inc  & ~prev_inc_q;
    assign dim_s        = days_in_month(bus.month, bus.year);

    // Next state, timeout counter, strobe requests and day clamp.
    always_comb begin
        state_d        = state_q;
        to_cnt_d       = to_cnt_q;
        day_b_d        = 1'b0;
        mon_b_d        = 1'b0;
        year_b_d       = 1'b0;
        day_load_d     = 1'b0;
        day_load_val_d = day_load_val_q;

        if (mode_press_s) begin
            // Mode wins over a simultaneous inc press; the inc is dropped.
            to_cnt_d = 6'd0;
            case (state_q)
                ST_RUN:      state_d = ST_SET_DAY;
                ST_SET_DAY:  state_d = ST_SET_MON;
                ST_SET_MON:  state_d = ST_SET_YEAR;
                ST_SET_YEAR: state_d = ST_RUN;
                default:     state_d = ST_RUN;
            endcase
        end else if (inc_press_s) begin
            // Any press restarts the inactivity window, even on a timeout tick.
            to_cnt_d = 6'd0;
            case (state_q)
                ST_SET_DAY:  day_b_d  = 1'b1;
                ST_SET_MON:  mon_b_d  = 1'b1;
                ST_SET_YEAR: year_b_d = 1'b1;
                default:     day_b_d  = 1'b0;
            endcase
        end else if (bus.tick_1hz && (state_q != ST_RUN)) begin
            if ((to_cnt_q + 6'd1) == TO_LIMIT) begin
                state_d  = ST_RUN;
                to_cnt_d = 6'd0;
            end else begin
                to_cnt_d = to_cnt_q + 6'd1;
            end
        end else begin
            to_cnt_d = to_cnt_q;
        end

        // Leaving month or year editing may leave e.g. 31 April; clamp it.
        if (((state_q == ST_SET_MON) || (state_q == ST_SET_YEAR)) && (state_d != state_q)) begin
            if (bus.day > dim_s) begin
                day_load_d     = 1'b1;
                day_load_val_d = dim_s;
            end else begin
                day_load_d     = 1'b0;
            end
        end else begin
            day_load_d = 1'b0;
        end
    end

    // State, button history, timeout counter and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= ST_RUN;
            prev_mode_q    <= 1'b1;
            prev_inc_q     <= 1'b1;
            to_cnt_q       <= 6'd0;
            tick_q         <= 1'b0;
            day_b_q        <= 1'b0;
            mon_b_q        <= 1'b0;
            year_b_q       <= 1'b0;
            day_load_q     <= 1'b0;
            day_load_val_q <= 5'd0;
        end else begin
            state_q        <= state_d;
            prev_mode_q    <= bus.btn_mode;
            prev_inc_q     <= bus.btn_inc;
            to_cnt_q       <= to_cnt_d;
            tick_q         <= bus.tick_1hz & (state_q == ST_RUN);
            day_b_q        <= day_b_d;
            mon_b_q        <= mon_b_d;
            year_b_q       <= year_b_d;
            day_load_q     <= day_load_d;
            day_load_val_q <= day_load_val_d;
        end
    end

    assign bus.mode         = state_q;
    assign bus.tick_o       = tick_q;
    assign bus.day_b        = day_b_q;
    assign bus.mon_b        = mon_b_q;
    assign bus.year_b       = year_b_q;
    assign bus.day_load     = day_load_q;
    assign bus.day_load_val = day_load_val_q;

endmodule

// File: tb/tb_date_set_ctrl.sv
// Directed bench for date_set_ctrl (built with a 3-tick timeout).
module tb_date_set_ctrl;

    logic clk;
    logic reset_n;
    int   checks;
    int   errors;

    date_set_ctrl_if bus();

    date_set_ctrl #(.TIMEOUT_S(3)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic press_mode();
        bus.btn_mode = 1'b1;
        step();
        bus.btn_mode = 1'b0;
        step();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        bus.btn_mode = 1'b1; bus.btn_inc = 1'b0; bus.tick_1hz = 1'b0;
        bus.day = 5'd1; bus.month = 4'd1; bus.year = 7'd0;
        #12;
        checks++; if (bus.mode !== 2'd0) begin errors++; $display("FAIL reset_mode: got %0d expected 0", bus.mode); end
        checks++; if ({bus.tick_o, bus.day_b, bus.mon_b, bus.year_b, bus.day_load} !== 5'b0) begin
            errors++; $display("FAIL reset_strobes: got %b expected 00000", {bus.tick_o, bus.day_b, bus.mon_b, bus.year_b, bus.day_load}); end
        checks++; if (bus.day_load_val !== 5'd0) begin errors++; $display("FAIL reset_load_val: got %0d expected 0", bus.day_load_val); end
        @(negedge clk);
        reset_n = 1'b1;
        step(); step();
        checks++; if (bus.mode !== 2'd0) begin errors++; $display("FAIL held_mode_no_press: got %0d expected 0", bus.mode); end
        bus.btn_mode = 1'b0;
        step();
        bus.btn_mode = 1'b1;
        step();
        checks++; if (bus.mode !== 2'd1) begin errors++; $display("FAIL first_press_after_reset: got %0d expected 1", bus.mode); end
        bus.btn_mode = 1'b0;
        step();
        press_mode(); press_mode(); press_mode();
        checks++; if (bus.mode !== 2'd0) begin errors++; $display("FAIL back_to_run: got %0d expected 0", bus.mode); end
    endtask

    task automatic test_run_tick_and_inc();
        bus.tick_1hz = 1'b1;
        step();
        bus.tick_1hz = 1'b0;
        checks++; if (bus.tick_o !== 1'b1) begin errors++; $display("FAIL run_tick: got %b expected 1", bus.tick_o); end
        step();
        checks++; if (bus.tick_o !== 1'b0) begin errors++; $display("FAIL run_tick_width: got %b expected 0", bus.tick_o); end
        bus.btn_inc = 1'b1;
        step();
        bus.btn_inc = 1'b0;
        checks++; if ({bus.day_b, bus.mon_b, bus.year_b} !== 3'b000 || bus.mode !== 2'd0) begin
            errors++; $display("FAIL run_inc_ignored: got strobes %b mode %0d expected 000 mode 0", {bus.day_b, bus.mon_b, bus.year_b}, bus.mode); end
        step();
    endtask

    task automatic test_set_sequence();
        logic [1:0] exp_mode [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
        for (int i = 0; i < 4; i++) begin
            bus.btn_mode = 1'b1;
            step();
            bus.btn_mode = 1'b0;
            checks++; if (bus.mode !== exp_mode[i]) begin errors++; $display("FAIL seq_mode_%0d: got %0d expected %0d", i, bus.mode, exp_mode[i]); end
            step();
            if (i == 0) begin
                bus.tick_1hz = 1'b1;
                step();
                bus.tick_1hz = 1'b0;
                checks++; if (bus.tick_o !== 1'b0) begin errors++; $display("FAIL set_tick_gated: got %b expected 0", bus.tick_o); end
                step();
            end
            if (i == 1) begin
                for (int k = 0; k < 3; k++) begin
                    bus.btn_inc = 1'b1;
                    step();
                    bus.btn_inc = 1'b0;
                    checks++; if ({bus.day_b, bus.mon_b, bus.year_b} !== 3'b010) begin
                        errors++; $display("FAIL mon_strobe_%0d: got %b expected 010", k, {bus.day_b, bus.mon_b, bus.year_b}); end
                    step();
                    checks++; if ({bus.day_b, bus.mon_b, bus.year_b} !== 3'b000) begin
                        errors++; $display("FAIL mon_strobe_low_%0d: got %b expected 000", k, {bus.day_b, bus.mon_b, bus.year_b}); end
                end
            end
        end
    endtask

    task automatic test_clamp_month();
        press_mode(); press_mode();
        bus.day = 5'd31; bus.month = 4'd4;
        bus.btn_mode = 1'b1;
        step();
        bus.btn_mode = 1'b0;
        checks++; if (bus.mode !== 2'd3 || bus.day_load !== 1'b1 || bus.day_load_val !== 5'd30) begin
            errors++; $display("FAIL clamp_apr: got mode %0d load %b val %0d expected mode 3 load 1 val 30", bus.mode, bus.day_load, bus.day_load_val); end
        step();
        checks++; if (bus.day_load !== 1'b0 || bus.day_load_val !== 5'd30) begin
            errors++; $display("FAIL clamp_apr_pulse: got load %b val %0d expected load 0 val 30", bus.day_load, bus.day_load_val); end
        bus.day = 5'd1;
        press_mode();
    endtask

    task automatic test_leap_clamp();
        bus.day = 5'd29; bus.month = 4'd1; bus.year = 7'd23;
        press_mode(); press_mode(); press_mode();
        bus.month = 4'd2;
        bus.btn_mode = 1'b1;
        step();
        bus.btn_mode = 1'b0;
        checks++; if (bus.mode !== 2'd0 || bus.day_load !== 1'b1 || bus.day_load_val !== 5'd28) begin
            errors++; $display("FAIL leap_y23: got mode %0d load %b val %0d expected mode 0 load 1 val 28", bus.mode, bus.day_load, bus.day_load_val); end
        step();
        bus.year = 7'd24;
        press_mode(); press_mode();
        bus.btn_mode = 1'b1;
        step();
        bus.btn_mode = 1'b0;
        checks++; if (bus.mode !== 2'd3 || bus.day_load !== 1'b0) begin
            errors++; $display("FAIL leap_y24_mon: got mode %0d load %b expected mode 3 load 0", bus.mode, bus.day_load); end
        step();
        bus.btn_mode = 1'b1;
        step();
        bus.btn_mode = 1'b0;
        checks++; if (bus.mode !== 2'd0 || bus.day_load !== 1'b0 || bus.day_load_val !== 5'd28) begin
            errors++; $display("FAIL leap_y24: got mode %0d load %b val %0d expected mode 0 load 0 val 28", bus.mode, bus.day_load, bus.day_load_val); end
        step();
        bus.day = 5'd1; bus.month = 4'd1;
    endtask

    task automatic test_timeout();
        press_mode();
        for (int t = 1; t <= 3; t++) begin
            bus.tick_1hz = 1'b1;
            step();
            bus.tick_1hz = 1'b0;
            checks++; if (bus.mode !== ((t == 3) ? 2'd0 : 2'd1)) begin
                errors++; $display("FAIL timeout_tick_%0d: got %0d expected %0d", t, bus.mode, (t == 3) ? 0 : 1); end
            step();
        end
        press_mode();
        for (int t = 1; t <= 2; t++) begin
            bus.tick_1hz = 1'b1; step(); bus.tick_1hz = 1'b0; step();
        end
        bus.tick_1hz = 1'b1; bus.btn_inc = 1'b1;
        step();
        bus.tick_1hz = 1'b0; bus.btn_inc = 1'b0;
        checks++; if (bus.mode !== 2'd1 || bus.day_b !== 1'b1) begin
            errors++; $display("FAIL timeout_press_wins: got mode %0d day_b %b expected mode 1 day_b 1", bus.mode, bus.day_b); end
        step();
        for (int t = 1; t <= 3; t++) begin
            bus.tick_1hz = 1'b1;
            step();
            bus.tick_1hz = 1'b0;
            checks++; if (bus.mode !== ((t == 3) ? 2'd0 : 2'd1)) begin
                errors++; $display("FAIL timeout_restart_%0d: got %0d expected %0d", t, bus.mode, (t == 3) ? 0 : 1); end
            step();
        end
    endtask

    task automatic test_simultaneous();
        press_mode();
        bus.btn_mode = 1'b1; bus.btn_inc = 1'b1;
        step();
        bus.btn_mode = 1'b0; bus.btn_inc = 1'b0;
        checks++; if (bus.mode !== 2'd2 || bus.day_b !== 1'b0 || bus.mon_b !== 1'b0) begin
            errors++; $display("FAIL simul_press: got mode %0d day_b %b mon_b %b expected mode 2 0 0", bus.mode, bus.day_b, bus.mon_b); end
        step();
        checks++; if (bus.day_b !== 1'b0 || bus.mon_b !== 1'b0) begin
            errors++; $display("FAIL simul_after: got day_b %b mon_b %b expected 0 0", bus.day_b, bus.mon_b); end
    endtask

    task automatic test_back_to_back();
        int n;
        // Currently SET_MON: move to SET_YEAR for year strobes.
        press_mode();
        n = 0;
        bus.btn_inc = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step();
            if (bus.year_b === 1'b1) n++;
        end
        bus.btn_inc = 1'b0;
        step();
        checks++; if (n !== 1) begin errors++; $display("FAIL held_inc: got %0d strobes expected 1", n); end
        bus.btn_inc = 1'b1; step();
        checks++; if (bus.year_b !== 1'b1) begin errors++; $display("FAIL b2b_first: got %b expected 1", bus.year_b); end
        bus.btn_inc = 1'b0; step();
        checks++; if (bus.year_b !== 1'b0) begin errors++; $display("FAIL b2b_gap: got %b expected 0", bus.year_b); end
        bus.btn_inc = 1'b1; step();
        checks++; if (bus.year_b !== 1'b1) begin errors++; $display("FAIL b2b_second: got %b expected 1", bus.year_b); end
        bus.btn_inc = 1'b0; step();
    endtask

    task automatic test_reset_mid();
        // Currently SET_YEAR: a pending strobe is killed by reset.
        bus.btn_inc = 1'b1;
        step();
        #2;
        reset_n = 1'b0;
        #1;
        checks++; if (bus.mode !== 2'd0 || bus.year_b !== 1'b0) begin
            errors++; $display("FAIL reset_mid: got mode %0d year_b %b expected mode 0 year_b 0", bus.mode, bus.year_b); end
        bus.btn_inc = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        step();
        checks++; if (bus.mode !== 2'd0) begin errors++; $display("FAIL reset_mid_after: got %0d expected 0", bus.mode); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_run_tick_and_inc();
        test_set_sequence();
        test_clamp_month();
        test_leap_clamp();
        test_timeout();
        test_simultaneous();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/date_set_ctrl.md
# date_set_ctrl

Setting-mode controller for the calendar datapath (day / month / year counters). It turns two debounced push-buttons into a set-mode state machine and gates the running 1 Hz tick while the user edits. It issues single-cycle increment strobes to the selected counter, returns to run mode on inactivity timeout, and clamps the day to the length of the month (leap-aware) when an edit leaves an illegal date.

## Interface
- TIMEOUT_S, 30: number of `tick_1hz` pulses with no button press before a set state falls back to RUN; legal range 1..63.
- clk  in  1  system clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- tick_1hz  in  1  one-`clk`-cycle pulse, once per second.
- btn_mode  in  1  debounced level; each rising edge is one mode press.
- btn_inc  in  1  debounced level; each rising edge is one increment press.
- day  in  5  current day from the day counter, 1..31.
- month  in  4  current month from the month counter, 1..12.
- year  in  7  current year offset from 2000, 0..99.
- tick_o  out  1  gated second tick to the counter chain.
- day_b  out  1  one-cycle day-increment strobe.
- mon_b  out  1  one-cycle month-increment strobe.
- year_b  out  1  one-cycle year-increment strobe.
- day_load  out  1  one-cycle strobe; the day counter loads `day_load_val`.
- day_load_val  out  5  clamp value, valid while `day_load` = 1.
- mode  out  2  current state: 0 RUN, 1 SET_DAY, 2 SET_MON, 3 SET_YEAR.

## Operation
- **Edge detect.**
  - `btn_mode` and `btn_inc` are each compared against a registered previous value.
  - A press is `btn & ~prev`.
  - The prev registers reset to 1, so a button held through reset release does not produce a press.
- **State machine.** A mode press advances RUN → SET_DAY → SET_MON → SET_YEAR → RUN.
- **Increment in a set state.**
  - An inc press drives exactly one strobe: `day_b` in SET_DAY, `mon_b` in SET_MON, `year_b` in SET_YEAR.
  - In RUN, inc presses are ignored.
- **Simultaneous presses.** Mode and inc pressed in the same cycle: mode wins, the inc press is discarded and no strobe is issued.
- **Tick gating.** `tick_o` = `tick_1hz` registered, and only while `mode` = RUN. No tick reaches the counters in any set state.
- **Timeout counter.**
  - 6-bit counter, cleared on entry to any set state and on any button press.
  - Increments on each `tick_1hz` while in a set state.
  - When it would reach TIMEOUT_S, the state goes to RUN and the counter clears.
  - A press in the same cycle as the timeout tick wins: the counter clears and the state does not change unless the press was a mode press.
- **Days in month (dim).**
  - 31 for months 1, 3, 5, 7, 8, 10, 12.
  - 30 for months 4, 6, 9, 11.
  - For month 2: 29 if `year[1:0]` = 0, else 28.
- **Clamp.**
  - Evaluated on every transition out of SET_MON or SET_YEAR, whether by mode press or timeout, using the `day`, `month` and `year` inputs sampled on that edge.
  - If `day` > dim: `day_load` = 1 and `day_load_val` = dim for one cycle.
  - Otherwise `day_load` = 0; `day_load_val` holds its last value.
- **Reset mid-operation.** Asserting `reset_n` low in any state immediately forces the reset values below. Pending strobes are dropped.

## Timing
- **Reset values:**
  - `mode` = 0 (RUN)
  - `tick_o`, `day_b`, `mon_b`, `year_b`, `day_load` = 0
  - `day_load_val` = 0
  - timeout counter = 0
  - prev registers = 1
- **Press latency.** Button rising edge sampled at clock edge k:
  - `mode` changes after edge k.
  - The inc strobe is high from edge k to edge k+1 (registered, exactly one cycle).
- **Tick latency.** `tick_1hz` high before edge k gives `tick_o` high for the cycle after edge k, if `mode` was RUN at edge k.
- **Clamp latency.** `day_load` is asserted in the cycle right after the transition edge, with `mode` already showing the new state.
- **Held buttons.** A held button produces one press only; it must go low for at least one `clk` cycle before it can produce another.
- **Strobe spacing.** Strobes are never wider than one cycle. Two consecutive presses produce two separate strobes.

## Test plan
- **Reset:** reset_n low with `btn_mode` held high, then release → `mode` = 0, all strobes 0, no mode advance until `btn_mode` falls and rises again.
- **Set sequence:** in RUN, 4 mode presses → `mode` reads 1, 2, 3, 0. Three inc presses in SET_MON → exactly three 1-cycle `mon_b` pulses and no `day_b` or `year_b`. `tick_o` stays 0 while `mode` ≠ 0.
- **Clamp on month leave:** day = 31, month = 4, press mode in SET_MON → `mode` = 3, `day_load` = 1 for one cycle with `day_load_val` = 30.
- **Leap clamp on year leave:** day = 29, month = 2; leave SET_YEAR once with year = 23, once with year = 24 → with 23, `day_load` = 1 and `day_load_val` = 28; with 24, no `day_load`.
- **Timeout:** TIMEOUT_S = 3, enter SET_DAY, no presses, three `tick_1hz` pulses → `mode` = 0 after the third. Repeat with an inc press on the third tick's cycle → `mode` stays 1, `day_b` pulses, counter restarts.
- **Simultaneous presses:** mode and inc rise in the same cycle in SET_DAY → `mode` = 2, no `day_b` or `mon_b` strobe.
